// File: rtl/seg7_scan_out_pkg.sv
// seg7_scan_out_pkg: segment patterns, key codes and scan states shared by the display path
package seg7_scan_out_pkg;
  localparam logic [7:0] SEG_0 = 8'hC0, SEG_1 = 8'hF9, SEG_2 = 8'hA4, SEG_3 = 8'hB0, SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92, SEG_6 = 8'h82, SEG_7 = 8'hF8, SEG_8 = 8'h80, SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] KEY_BS = 4'hA, KEY_CLR = 4'hB;
  typedef enum logic {SHOW, BLANK} scan_state_t;
endpackage

// File: rtl/seg7_scan_out_dec.sv
// seg7_dec: digit + valid to active-low {dp,g,f,e,d,c,b,a}; invalid or non-decimal shows blank
module seg7_dec
  import seg7_scan_out_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_valid,
  output logic [7:0] o_seg
);
  always_comb
    o_seg = !i_valid      ? SEG_BLANK :
            i_digit == 4'd0 ? SEG_0 : i_digit == 4'd1 ? SEG_1 : i_digit == 4'd2 ? SEG_2 :
            i_digit == 4'd3 ? SEG_3 : i_digit == 4'd4 ? SEG_4 : i_digit == 4'd5 ? SEG_5 :
            i_digit == 4'd6 ? SEG_6 : i_digit == 4'd7 ? SEG_7 : i_digit == 4'd8 ? SEG_8 :
            i_digit == 4'd9 ? SEG_9 : SEG_BLANK;
endmodule

// File: rtl/seg7_scan_out.sv
// seg7_scan_out: key-digit buffer driving a multiplexed, blinkable 7-segment display
module seg7_scan_out
  import seg7_scan_out_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_DIV = 8
) (
  input  logic            ck,
  input  logic            reset,
  input  logic            scan_tick,
  input  logic            blink_tick,
  input  logic            blink,
  input  logic            clr,
  input  logic [3:0]      keycode,
  input  logic            keyenbl,
  output logic [NDIG-1:0] digsel,
  output logic [7:0]      seg,
  output logic [3:0]      ndigits
);
  localparam int PW = $clog2(NDIG);
  localparam int BW = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
  localparam int KW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [NDIG-1:0][3:0] r_dig;
  logic [NDIG-1:0]      r_val;
  logic [3:0]           r_cnt;
  logic                 w_push, w_bs, w_clr;
  scan_state_t          r_state, w_state;
  logic [PW-1:0]        r_ptr, w_ptr;
  logic [BW-1:0]        r_bcnt, w_bcnt;
  logic                 r_phase;
  logic [KW-1:0]        r_bk;
  logic [7:0]           w_seg, r_seg;
  logic [NDIG-1:0]      r_digsel;
  assign w_push = keyenbl && keycode <= 4'd9;
  assign w_bs   = keyenbl && keycode == KEY_BS && r_val[0];
  assign w_clr  = clr || (keyenbl && keycode == KEY_CLR);
  // slot 0 holds the newest digit; valid bits are always contiguous from slot 0
  always_ff @(posedge ck or posedge reset)
    if (reset) begin
      r_dig <= '0;
      r_val <= '0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_dig <= {r_dig[NDIG-2:0], keycode};
      r_val <= {r_val[NDIG-2:0], 1'b1};
      r_cnt <= r_cnt == 4'(NDIG) ? r_cnt : r_cnt + 4'd1;
    end else if (w_bs) begin
      r_dig <= {4'h0, r_dig[NDIG-1:1]};
      r_val <= {1'b0, r_val[NDIG-1:1]};
      r_cnt <= r_cnt - 4'd1;
    end
  always_ff @(posedge ck or posedge reset)
    if (reset) begin
      r_state <= SHOW;
      r_ptr   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_bcnt  <= w_bcnt;
    end
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_bcnt  = r_bcnt;
    if (r_state == SHOW && scan_tick) begin
      w_state = BLANK;
      w_bcnt  = BW'(BLANK_CYC - 1);
    end else if (r_state == BLANK) begin
      w_bcnt  = r_bcnt - BW'(1);
      w_state = r_bcnt == '0 ? SHOW : BLANK;
      w_ptr   = r_bcnt != '0 ? r_ptr : r_ptr == PW'(NDIG - 1) ? '0 : r_ptr + PW'(1);
    end
  end
  always_ff @(posedge ck or posedge reset)
    if (reset) begin
      r_phase <= 1'b1;
      r_bk    <= '0;
    end else if (!blink) begin
      r_phase <= 1'b1;
      r_bk    <= '0;
    end else if (blink_tick) begin
      r_phase <= r_bk == KW'(BLINK_DIV - 1) ? ~r_phase : r_phase;
      r_bk    <= r_bk == KW'(BLINK_DIV - 1) ? '0 : r_bk + KW'(1);
    end
  seg7_dec u_dec (
    .i_digit(r_dig[r_ptr]),
    .i_valid(r_val[r_ptr]),
    .o_seg  (w_seg)
  );
  // dropping blink forces the display on at the very next edge, ahead of the phase register
  always_ff @(posedge ck or posedge reset)
    if (reset) begin
      r_digsel <= '1;
      r_seg    <= SEG_BLANK;
    end else begin
      r_digsel <= (r_state == SHOW && (r_phase || !blink)) ? ~(NDIG'(1) << r_ptr) : '1;
      r_seg    <= r_state == SHOW ? w_seg : SEG_BLANK;
    end
  assign digsel  = r_digsel;
  assign seg     = r_seg;
  assign ndigits = r_cnt;
endmodule

// File: tb/tb_seg7_scan_out.sv
// tb_seg7_scan_out: directed checks of buffer, scan timing, wrap, reset and blink
module tb_seg7_scan_out;
  logic       ck, reset, scan_tick, blink_tick, blink, clr, keyenbl;
  logic [3:0] keycode;
  logic [3:0] digsel;
  logic [7:0] seg;
  logic [3:0] ndigits;
  int n_chk = 0;
  int n_fail = 0;
  seg7_scan_out #(.NDIG(4), .BLANK_CYC(2), .BLINK_DIV(8)) dut (
    .ck(ck), .reset(reset), .scan_tick(scan_tick), .blink_tick(blink_tick), .blink(blink),
    .clr(clr), .keycode(keycode), .keyenbl(keyenbl), .digsel(digsel), .seg(seg), .ndigits(ndigits)
  );
  initial begin
    ck = 0;
    forever #5 ck = ~ck;
  end
  always @(negedge ck) begin
    n_chk++;
    assert ($countones(~digsel) <= 1) else begin
      n_fail++;
      $error("FAIL onehot observed=%b expected=at most one low", digsel);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge ck);
    #1;
  endtask
  task automatic key(input logic [3:0] k);
    keycode = k;
    keyenbl = 1;
    step;
    keyenbl = 0;
  endtask
  task automatic scan_chk(input string tag, input logic [3:0] prev_ds, input logic [3:0] exp_ds,
                          input logic [7:0] exp_seg, input bit extra_ticks);
    scan_tick = 1;
    step;
    scan_tick = extra_ticks;
    chk({tag, "_pre"}, digsel, prev_ds);
    step;
    chk({tag, "_blank1"}, digsel, 4'hF);
    chk({tag, "_blank1_seg"}, seg, 8'hFF);
    step;
    scan_tick = 0;
    chk({tag, "_blank2"}, digsel, 4'hF);
    step;
    chk({tag, "_ds"}, digsel, exp_ds);
    chk({tag, "_seg"}, seg, exp_seg);
  endtask
  task automatic blink_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      blink_tick = 1;
      step;
      blink_tick = 0;
      step;
    end
  endtask
  initial begin
    reset = 1; scan_tick = 0; blink_tick = 0; blink = 0; clr = 0; keyenbl = 0; keycode = 0;
    step;
    chk("rst_ds", digsel, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_nd", ndigits, 4'd0);
    reset = 0;
    step;
    chk("idle_ds", digsel, 4'hE);
    chk("idle_seg", seg, 8'hFF);
    key(4'd1); key(4'd2); key(4'd3);
    chk("nd3", ndigits, 4'd3);
    step;
    chk("p0_ds", digsel, 4'hE);
    chk("p0_seg", seg, 8'hB0);
    scan_chk("p1", 4'hE, 4'hD, 8'hA4, 1);
    scan_chk("p2", 4'hD, 4'hB, 8'hF9, 0);
    scan_chk("p3", 4'hB, 4'h7, 8'hFF, 0);
    scan_chk("wrap", 4'h7, 4'hE, 8'hB0, 0);
    key(4'd4); key(4'd5);
    chk("nd_full", ndigits, 4'd4);
    step;
    chk("full_s0", seg, 8'h92);
    scan_chk("full_s1", 4'hE, 4'hD, 8'h99, 0);
    scan_chk("full_s2", 4'hD, 4'hB, 8'hB0, 0);
    #2 reset = 1;
    #1;
    chk("midrst_ds", digsel, 4'hF);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_nd", ndigits, 4'd0);
    step;
    reset = 0;
    step;
    chk("postrst_ds", digsel, 4'hE);
    chk("postrst_seg", seg, 8'hFF);
    for (int i = 1; i <= 5; i++) key(4'(i));
    chk("refill_nd", ndigits, 4'd4);
    key(4'hA); chk("bs1", ndigits, 4'd3);
    key(4'hA); chk("bs2", ndigits, 4'd2);
    key(4'hA); chk("bs3", ndigits, 4'd1);
    chk("bs3_seg", seg, 8'hB0);
    key(4'hA); chk("bs4", ndigits, 4'd0);
    key(4'hA); chk("bs5", ndigits, 4'd0);
    step;
    chk("empty_seg", seg, 8'hFF);
    key(4'd7); key(4'd8);
    key(4'hC); chk("ign_c", ndigits, 4'd2);
    key(4'hF); chk("ign_f", ndigits, 4'd2);
    key(4'hB); chk("kclr", ndigits, 4'd0);
    key(4'd9); chk("nd1", ndigits, 4'd1);
    clr = 1;
    key(4'd7);
    clr = 0;
    chk("clr_prio", ndigits, 4'd0);
    step;
    chk("clr_seg", seg, 8'hFF);
    key(4'd6);
    step;
    chk("six_seg", seg, 8'h82);
    blink = 1;
    blink_ticks(7);
    chk("blink_on7", digsel, 4'hE);
    blink_ticks(1);
    chk("blink_off", digsel, 4'hF);
    blink_ticks(7);
    chk("blink_off15", digsel, 4'hF);
    blink_ticks(1);
    chk("blink_on2", digsel, 4'hE);
    blink_ticks(8);
    chk("blink_off2", digsel, 4'hF);
    blink = 0;
    step;
    chk("blink_drop", digsel, 4'hE);
    chk("blink_drop_seg", seg, 8'h82);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
